uart_tx_fifo_drain: RTL and testbench

- UART transmitter that sits directly downstream of the TX byte FIFO.
- Pops one byte whenever the FIFO is non-empty and serialises it on `tx`: start bit, DATA_WIDTH data bits LSB-first, optional parity, then STOP_BITS stop bits.
- Frames go out back-to-back with no idle gap while data remains.
- Consumes the FIFO's fall-through read port: `rdata` is valid whenever `empty` is low.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx_fifo_drain.sv | 147 ++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX blocks: FSM state encoding,
// parity mode constants and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clock cycles per bit period, truncating; callers keep the result >= 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and wraps, with a one-cycle
// bit_end strobe on the final count. Shared between the TX and RX blocks.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = (cnt_q == CNT_LAST);

    // Next count: held at zero while cleared, wraps after the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter fed straight from a fall-through TX FIFO. Each frame pops
// exactly one byte at the edge the start bit begins; frames run back-to-back
// while the FIFO has data.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int               IDX_W        = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST    = (STOP_BITS == 2);

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic                  stop_q;
    logic                  tx_q;
    logic                  rd_en_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  parity_d;
    logic                  bit_end;
    logic                  timer_clr;

    // The timer idles at zero so the start bit always gets a full period.
    assign timer_clr = (state_q == ST_IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (timer_clr),
        .bit_end_o(bit_end)
    );

    // Next data-bit index and the parity bit over the latched byte.
    always_comb begin
        idx_d    = idx_q + 1'b1;
        parity_d = (^shift_q) ^ (PARITY == PAR_ODD);
    end

    // Frame sequencer; every output is a register so tx never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_rdata;
                        rd_en_q <= 1'b1;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= parity_d;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                stop_q  <= 1'b0;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            idx_q <= idx_d;
                            tx_q  <= shift_q[idx_d];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_q == STOP_LAST) begin
                            done_q <= 1'b1;
                            // FIFO is only looked at here and in IDLE: one pop per frame.
                            if (!fifo_empty) begin
                                shift_q <= fifo_rdata;
                                rd_en_q <= 1'b1;
                                tx_q    <= 1'b0;
                                state_q <= ST_START;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four instances (no parity, even, odd, two stop
// bits) at 8 clocks per bit, each fed by a fall-through FIFO model, compared
// every cycle against a frame-level model plus directed literal checks.
module tb_uart_tx_fifo_drain;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0] empty_w, rd_w, tx_w, busy_w, done_w;
    logic [7:0] rdata_w [4];

    logic [7:0] fmem [4][16];
    int fhead [4];
    int ftail [4];
    int mhead [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pops      [4];
    int dones     [4];
    int start_cyc [4];
    int done_cyc  [4];

    bit [3:0]   m_act    = '0;
    int         m_cyc [4];
    logic [7:0] m_byte [4];
    bit [3:0]   exp_tx   = '1;
    bit [3:0]   exp_busy = '0;
    bit [3:0]   exp_rd   = '0;
    bit [3:0]   exp_done = '0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign empty_w[g] = (fhead[g] == ftail[g]);
        assign rdata_w[g] = fmem[g][fhead[g] % 16];

        uart_tx_fifo_drain #(
            .CLK_FREQ  (80),
            .BAUD      (10),
            .DATA_WIDTH(8),
            .PARITY    ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .STOP_BITS ((g == 3) ? 2 : 1)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .fifo_empty(empty_w[g]),
            .fifo_rdata(rdata_w[g]),
            .fifo_rd_en(rd_w[g]),
            .tx        (tx_w[g]),
            .tx_busy   (busy_w[g]),
            .tx_done   (done_w[g])
        );
    end

    function automatic int par_of(input int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    function automatic int flen(input int i);
        return 1 + 8 + ((par_of(i) != 0) ? 1 : 0) + ((i == 3) ? 2 : 1);
    endfunction

    // Bit k of the serial frame carrying byte b on instance i.
    function automatic logic frame_bit(input int i, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (par_of(i) != 0 && k == 9) return (^b) ^ (par_of(i) == 2);
        return 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: a frame lasts flen*CPB cycles from the pop edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act    = '0;
            exp_tx   = '1;
            exp_busy = '0;
            exp_rd   = '0;
            exp_done = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_rd[i]   = 1'b0;
                exp_done[i] = 1'b0;
                if (m_act[i]) begin
                    m_cyc[i] = m_cyc[i] + 1;
                    if (m_cyc[i] == flen(i) * CPB) begin
                        exp_done[i] = 1'b1;
                        m_act[i]    = 1'b0;
                    end
                end
                if (!m_act[i] && mhead[i] != ftail[i]) begin
                    m_byte[i] = fmem[i][mhead[i] % 16];
                    mhead[i]  = mhead[i] + 1;
                    m_act[i]  = 1'b1;
                    m_cyc[i]  = 0;
                    exp_rd[i] = 1'b1;
                end
                exp_tx[i]   = m_act[i] ? frame_bit(i, m_byte[i], m_cyc[i] / CPB) : 1'b1;
                exp_busy[i] = m_act[i];
            end
        end
    end

    // Per-cycle compare against the model, then FIFO pop and event bookkeeping.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            checks = checks + 1;
            if (tx_w[i] !== exp_tx[i] || busy_w[i] !== exp_busy[i] ||
                rd_w[i] !== exp_rd[i] || done_w[i] !== exp_done[i]) begin
                failures = failures + 1;
                $display("FAIL cycle_cmp inst=%0d cyc=%0d got tx/busy/rd/done=%b%b%b%b want=%b%b%b%b",
                         i, cyc, tx_w[i], busy_w[i], rd_w[i], done_w[i],
                         exp_tx[i], exp_busy[i], exp_rd[i], exp_done[i]);
            end
            if (rd_w[i] === 1'b1) begin
                if (fhead[i] == ftail[i]) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("FAIL pop_empty inst=%0d cyc=%0d got pop of empty FIFO want none", i, cyc);
                end else begin
                    fhead[i] = fhead[i] + 1;
                end
                pops[i]      = pops[i] + 1;
                start_cyc[i] = cyc;
            end
            if (done_w[i] === 1'b1) begin
                dones[i]    = dones[i] + 1;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        fmem[i][ftail[i] % 16] = b;
        ftail[i] = ftail[i] + 1;
    endtask

    task automatic wait_pops(input int i, input int target, input string name);
        int n = 0;
        while (pops[i] < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, int'(pops[i] >= target), 1);
    endtask

    task automatic wait_dones(input int i, input int target, input string name);
        int n = 0;
        while (dones[i] < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, int'(dones[i] >= target), 1);
    endtask

    int s;
    logic [9:0] got;

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++)
                fmem[i][j] = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_tx", int'(tx_w), 15);
        chk("reset_busy", int'(busy_w), 0);
        chk("reset_rd_en", int'(rd_w), 0);
        chk("reset_done", int'(done_w), 0);

        // Idle with an empty FIFO.
        @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        chk("idle_pops", pops[0] + pops[1] + pops[2] + pops[3], 0);
        chk("idle_dones", dones[0] + dones[1] + dones[2] + dones[3], 0);
        chk("idle_tx", int'(tx_w), 15);

        // Single byte 0xA5.
        @(negedge clk);
        push(0, 8'hA5);
        wait_pops(0, 1, "s2_pop_seen");
        s = start_cyc[0];
        repeat (4) @(negedge clk);
        #1;
        got[0] = tx_w[0];
        for (int k = 1; k < 10; k++) begin
            repeat (8) @(negedge clk);
            #1;
            got[k] = tx_w[0];
        end
        chk("s2_bits", int'(got), int'(10'b1101001010));
        wait_dones(0, 1, "s2_done_seen");
        chk("s2_frame_len", done_cyc[0] - s, 80);
        chk("s2_busy_after", int'(busy_w[0]), 0);
        chk("s2_pops", pops[0], 1);

        // Two queued bytes go out back-to-back.
        @(negedge clk);
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_pops(0, 2, "s3_pop1_seen");
        s = start_cyc[0];
        wait_pops(0, 3, "s3_pop2_seen");
        chk("s3_back_to_back", start_cyc[0] - s, 80);
        wait_dones(0, 3, "s3_done2_seen");
        chk("s3_total_len", done_cyc[0] - s, 160);
        repeat (20) @(negedge clk);
        #1;
        chk("s3_pops", pops[0], 3);
        chk("s3_dones", dones[0], 3);

        // Even and odd parity on 0x07.
        @(negedge clk);
        push(1, 8'h07);
        push(2, 8'h07);
        wait_pops(1, 1, "s4_pop_seen");
        repeat (76) @(negedge clk);
        #1;
        chk("s4_even_parity", int'(tx_w[1]), 1);
        chk("s4_odd_parity", int'(tx_w[2]), 0);
        wait_dones(1, 1, "s4_even_done_seen");
        chk("s4_even_len", done_cyc[1] - start_cyc[1], 88);
        wait_dones(2, 1, "s4_odd_done_seen");
        chk("s4_odd_len", done_cyc[2] - start_cyc[2], 88);

        // Reset during data bit 3 of 0x5A, then a fresh frame.
        @(negedge clk);
        push(0, 8'h5A);
        wait_pops(0, 4, "s5_pop_seen");
        repeat (35) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("s5_reset_tx", int'(tx_w[0]), 1);
        chk("s5_reset_busy", int'(busy_w[0]), 0);
        @(negedge clk);
        push(0, 8'h81);
        @(negedge clk);
        reset = 1'b0;
        wait_pops(0, 5, "s5_new_pop_seen");
        chk("s5_start_low", int'(tx_w[0]), 0);
        wait_dones(0, 4, "s5_done_seen");
        chk("s5_frame_len", done_cyc[0] - start_cyc[0], 80);
        repeat (10) @(negedge clk);
        #1;
        chk("s5_pops", pops[0], 5);

        // Two stop bits on 0x3C.
        @(negedge clk);
        push(3, 8'h3C);
        wait_pops(3, 1, "s6_pop_seen");
        s = start_cyc[3];
        repeat (68) @(negedge clk);
        #1;
        chk("s6_d7_low", int'(tx_w[3]), 0);
        repeat (8) @(negedge clk);
        #1;
        chk("s6_stop1", int'(tx_w[3]), 1);
        repeat (8) @(negedge clk);
        #1;
        chk("s6_stop2", int'(tx_w[3]), 1);
        wait_dones(3, 1, "s6_done_seen");
        chk("s6_frame_len", done_cyc[3] - s, 88);
        repeat (50) @(negedge clk);
        #1;
        chk("s6_pops", pops[3], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
